// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bus: branch-unit/decode qualifiers and harness handshake in,
// fetch address, run status and performance counters out.
interface fetch_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             start;
  logic             branch;
  logic [PC_W-1:0]  address;
  logic             halt_instr;
  logic             stall;
  logic [PC_W-1:0]  pc;
  logic             busy;
  logic             done;
  logic             fault;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] taken;

  modport master (
    output start, branch, address, halt_instr, stall,
    input  pc, busy, done, fault, retired, taken
  );

  modport slave (
    input  start, branch, address, halt_instr, stall,
    output pc, busy, done, fault, retired, taken
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencer: IDLE/RUN/DONE control, branch and halt
// handling, illegal-target fault and saturating retired/taken counters.
module fetch_sequencer #(
  parameter int          PC_W       = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned PROG_LEN   = 1024,
  parameter int          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.slave  fs
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // One extra bit so PROG_LEN = 2^PC_W is representable for the target check.
  localparam logic [PC_W:0]   PROG_LEN_W = (PC_W+1)'(PROG_LEN);
  localparam logic [PC_W-1:0] LAST_PC    = PC_W'(PROG_LEN - 1);
  localparam logic [PC_W-1:0] START_PC   = PC_W'(START_ADDR);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  logic             fault_q, fault_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // NOTE: every variable gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    taken_d   = taken_q;
    fault_d   = fault_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (fs.start) begin
          state_d   = S_RUN;
          pc_d      = START_PC;
          retired_d = '0;
          taken_d   = '0;
          fault_d   = 1'b0;
        end
      end

      S_RUN: begin
        // Every non-stalled cycle retires exactly one instruction.
        if (!fs.stall) begin
          retired_d = sat_inc(retired_q);
          if (fs.halt_instr) begin
            state_d = S_DONE;
          end else if (fs.branch) begin
            if ({1'b0, fs.address} < PROG_LEN_W) begin
              pc_d    = fs.address;
              taken_d = sat_inc(taken_q);
            end else begin
              fault_d = 1'b1;
              state_d = S_DONE;
            end
          end else if (pc_q == LAST_PC) begin
            state_d = S_DONE;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      retired_q <= '0;
      taken_q   <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      taken_q   <= taken_d;
      fault_q   <= fault_d;
    end
  end

  assign fs.pc      = pc_q;
  assign fs.busy    = (state_q == S_RUN);
  assign fs.done    = (state_q == S_DONE);
  assign fs.fault   = fault_q;
  assign fs.retired = retired_q;
  assign fs.taken   = taken_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table, directed corner
// sequences and random stimulus against a behavioural model.
module tb_fetch_sequencer;

  localparam int PC_W       = 10;
  localparam int CNT_A      = 4;
  localparam int LEN_A      = 200;
  localparam int START_A    = 0;
  localparam int CNT_B      = 16;
  localparam int LEN_B      = 1024;
  localparam int START_B    = 1020;
  localparam int SAT_A      = (1 << CNT_A) - 1;

  logic clk;
  logic reset_a, reset_b;
  int   tests_run = 0;
  int   tests_failed = 0;

  fetch_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_A)) bus_a ();
  fetch_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_B)) bus_b ();

  fetch_sequencer #(.PC_W(PC_W), .START_ADDR(START_A), .PROG_LEN(LEN_A), .CNT_W(CNT_A)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .fs    (bus_a.slave)
  );

  fetch_sequencer #(.PC_W(PC_W), .START_ADDR(START_B), .PROG_LEN(LEN_B), .CNT_W(CNT_B)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .fs    (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of dut_a.
  bit m_running, m_finished, m_fault;
  int m_pc, m_ret, m_tk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, st, br, input int addr, input bit hl, sl);
    if (rst) begin
      m_running = 0; m_finished = 0; m_fault = 0;
      m_pc = 0; m_ret = 0; m_tk = 0;
    end else if (!m_running) begin
      if (st) begin
        m_running = 1; m_finished = 0; m_fault = 0;
        m_pc = START_A; m_ret = 0; m_tk = 0;
      end
    end else if (!sl) begin
      m_ret = (m_ret < SAT_A) ? m_ret + 1 : SAT_A;
      if (hl) begin
        m_running = 0; m_finished = 1;
      end else if (br && addr < LEN_A) begin
        m_pc = addr;
        m_tk = (m_tk < SAT_A) ? m_tk + 1 : SAT_A;
      end else if (br) begin
        m_running = 0; m_finished = 1; m_fault = 1;
      end else if (m_pc == LEN_A - 1) begin
        m_running = 0; m_finished = 1;
      end else begin
        m_pc = m_pc + 1;
      end
    end
  endtask

  task automatic check_model();
    check("model.pc",      32'(bus_a.pc),      32'(m_pc));
    check("model.busy",    32'(bus_a.busy),    32'(m_running));
    check("model.done",    32'(bus_a.done),    32'(m_finished));
    check("model.fault",   32'(bus_a.fault),   32'(m_fault));
    check("model.retired", 32'(bus_a.retired), 32'(m_ret));
    check("model.taken",   32'(bus_a.taken),   32'(m_tk));
  endtask

  // Drive dut_a for one edge, advance the model, then compare away from the edge.
  task automatic apply(input bit rst, st, br, input int addr, input bit hl, sl);
    reset_a          = rst;
    bus_a.start      = st;
    bus_a.branch     = br;
    bus_a.address    = PC_W'(addr);
    bus_a.halt_instr = hl;
    bus_a.stall      = sl;
    @(posedge clk);
    model_step(rst, st, br, addr, hl, sl);
    #1;
    check_model();
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply_b(input bit rst, st, br, input int addr, input bit hl, sl);
    reset_b          = rst;
    bus_b.start      = st;
    bus_b.branch     = br;
    bus_b.address    = PC_W'(addr);
    bus_b.halt_instr = hl;
    bus_b.stall      = sl;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst, st, br;
    int addr;
    bit hl, sl;
    int pc;
    bit busy, done, fault;
    int ret, tk;
  } vec_t;

  vec_t vecs[17];

  initial begin
    reset_a = 1; reset_b = 1;
    bus_a.start = 0; bus_a.branch = 0; bus_a.address = '0; bus_a.halt_instr = 0; bus_a.stall = 0;
    bus_b.start = 0; bus_b.branch = 0; bus_b.address = '0; bus_b.halt_instr = 0; bus_b.stall = 0;

    // Linear run to a halt at pc=5, then restart and branch 3 -> 28, halt at 30.
    //           rst st br addr hl sl   pc busy done flt ret tk
    vecs[0]  = '{1, 0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0,  0,  0, 0,   0, 1, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0,  0,  0, 0,   1, 1, 0, 0, 1, 0};
    vecs[3]  = '{0, 0, 0,  0,  0, 0,   2, 1, 0, 0, 2, 0};
    vecs[4]  = '{0, 0, 0,  0,  0, 0,   3, 1, 0, 0, 3, 0};
    vecs[5]  = '{0, 0, 0,  0,  0, 0,   4, 1, 0, 0, 4, 0};
    vecs[6]  = '{0, 0, 0,  0,  0, 0,   5, 1, 0, 0, 5, 0};
    vecs[7]  = '{0, 0, 0,  0,  1, 0,   5, 0, 1, 0, 6, 0};
    vecs[8]  = '{0, 0, 0,  0,  0, 0,   5, 0, 1, 0, 6, 0};
    vecs[9]  = '{0, 1, 0,  0,  0, 0,   0, 1, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 0,  0,  0, 0,   1, 1, 0, 0, 1, 0};
    vecs[11] = '{0, 0, 0,  0,  0, 0,   2, 1, 0, 0, 2, 0};
    vecs[12] = '{0, 0, 0,  0,  0, 0,   3, 1, 0, 0, 3, 0};
    vecs[13] = '{0, 0, 1, 28,  0, 0,  28, 1, 0, 0, 4, 1};
    vecs[14] = '{0, 0, 0,  0,  0, 0,  29, 1, 0, 0, 5, 1};
    vecs[15] = '{0, 0, 0,  0,  0, 0,  30, 1, 0, 0, 6, 1};
    vecs[16] = '{0, 0, 0,  0,  1, 0,  30, 0, 1, 0, 7, 1};

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].rst, vecs[i].st, vecs[i].br, vecs[i].addr, vecs[i].hl, vecs[i].sl);
      check($sformatf("vec%0d.pc", i),      32'(bus_a.pc),      32'(vecs[i].pc));
      check($sformatf("vec%0d.busy", i),    32'(bus_a.busy),    32'(vecs[i].busy));
      check($sformatf("vec%0d.done", i),    32'(bus_a.done),    32'(vecs[i].done));
      check($sformatf("vec%0d.fault", i),   32'(bus_a.fault),   32'(vecs[i].fault));
      check($sformatf("vec%0d.retired", i), 32'(bus_a.retired), 32'(vecs[i].ret));
      check($sformatf("vec%0d.taken", i),   32'(bus_a.taken),   32'(vecs[i].tk));
    end

    // Stall overrides branch for 3 cycles, then halt beats a simultaneous branch.
    apply(0, 1, 0, 0, 0, 0);
    idle_a(2);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 1, 50, 0, 1);
      check("stall.pc", 32'(bus_a.pc), 32'd2);
      check("stall.retired", 32'(bus_a.retired), 32'd2);
      check("stall.taken", 32'(bus_a.taken), 32'd0);
    end
    apply(0, 0, 1, 50, 1, 0);
    check("halt_vs_branch.done", 32'(bus_a.done), 32'd1);
    check("halt_vs_branch.pc", 32'(bus_a.pc), 32'd2);
    check("halt_vs_branch.taken", 32'(bus_a.taken), 32'd0);

    // Illegal target ends the run with a fault; restart clears it.
    apply(0, 1, 0, 0, 0, 0);
    idle_a(1);
    apply(0, 0, 1, 300, 0, 0);
    check("illegal.done", 32'(bus_a.done), 32'd1);
    check("illegal.fault", 32'(bus_a.fault), 32'd1);
    check("illegal.pc", 32'(bus_a.pc), 32'd1);
    idle_a(2);
    check("illegal.hold_fault", 32'(bus_a.fault), 32'd1);
    apply(0, 1, 0, 0, 0, 0);
    check("restart.fault", 32'(bus_a.fault), 32'd0);
    check("restart.retired", 32'(bus_a.retired), 32'd0);
    check("restart.pc", 32'(bus_a.pc), 32'(START_A));

    // Fall off the end of the ROM (also saturates retired); start ignored in RUN.
    apply(0, 1, 0, 0, 0, 0);
    idle_a(LEN_A - 2);
    check("end.pc_last", 32'(bus_a.pc), 32'(LEN_A - 1));
    check("end.busy", 32'(bus_a.busy), 32'd1);
    check("end.ret_sat", 32'(bus_a.retired), 32'(SAT_A));
    idle_a(1);
    check("end.done", 32'(bus_a.done), 32'd1);
    check("end.fault", 32'(bus_a.fault), 32'd0);
    check("end.pc_hold", 32'(bus_a.pc), 32'(LEN_A - 1));

    // Reset with a simultaneous start in mid-run.
    apply(0, 1, 0, 0, 0, 0);
    idle_a(4);
    check("midrun.pc", 32'(bus_a.pc), 32'd4);
    apply(1, 1, 0, 0, 0, 0);
    check("reset.busy", 32'(bus_a.busy), 32'd0);
    check("reset.pc", 32'(bus_a.pc), 32'd0);
    check("reset.retired", 32'(bus_a.retired), 32'd0);
    idle_a(2);
    check("reset.stays_idle", 32'(bus_a.busy), 32'd0);

    // Self-loop branch for 20 cycles saturates both counters at 15.
    apply(0, 1, 0, 0, 0, 0);
    idle_a(1);
    for (int i = 0; i < 20; i++) apply(0, 0, 1, 1, 0, 0);
    check("sat.retired", 32'(bus_a.retired), 32'(SAT_A));
    check("sat.taken", 32'(bus_a.taken), 32'(SAT_A));
    check("sat.pc", 32'(bus_a.pc), 32'd1);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, 255)),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0));
    end

    // Full-size ROM with non-zero start: pc 1023 is the last word and must not wrap.
    apply_b(1, 1, 0, 0, 0, 0);
    check("b.reset.pc", 32'(bus_b.pc), 32'd0);
    check("b.reset.done", 32'(bus_b.done), 32'd0);
    apply_b(0, 1, 0, 0, 0, 0);
    check("b.start.pc", 32'(bus_b.pc), 32'(START_B));
    check("b.start.busy", 32'(bus_b.busy), 32'd1);
    for (int i = 0; i < 3; i++) apply_b(0, 0, 0, 0, 0, 0);
    check("b.last.pc", 32'(bus_b.pc), 32'd1023);
    apply_b(0, 0, 0, 0, 0, 0);
    check("b.end.done", 32'(bus_b.done), 32'd1);
    check("b.end.pc", 32'(bus_b.pc), 32'd1023);
    check("b.end.fault", 32'(bus_b.fault), 32'd0);
    check("b.end.retired", 32'(bus_b.retired), 32'd4);
    apply_b(0, 1, 0, 0, 0, 0);
    apply_b(0, 0, 1, 1023, 0, 0);
    check("b.branch_top.pc", 32'(bus_b.pc), 32'd1023);
    check("b.branch_top.taken", 32'(bus_b.taken), 32'd1);
    check("b.branch_top.fault", 32'(bus_b.fault), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
